// File: rtl/doodlejump_soc_ocimem_arbiter.sv
// ---------------------------------------------------------------------------
// doodlejump_soc_ocimem_arbiter
//
// Shares the Nios II on-chip debug RAM between the CPU monitor bus and the
// JTAG debug-slave command path. Requesters are served round-robin, except
// that JTAG always wins while the CPU sits in debug (debugack=1). Each access
// is one RAM strobe cycle, an optional read-latency wait, then one completion
// cycle.
//
// Ports
//   clk, reset_n                 system clock, async active-low reset
//   debugack                     CPU halted in debug; JTAG gets priority
//   cpu_*                        CPU request (held) / waitrequest / readdata
//   jtag_req/we/addr/wdata       single-cycle JTAG command pulse + payload
//   jtag_ack/rdata/overrun       completion pulse, held read data, sticky drop
//   mem_*                        OCI RAM strobes, address, data, byte enables
//   grant_jtag                   current or most recent owner is JTAG
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | arbitrate pending requests, load RAM address/data on grant
// GRANT  | RAM strobe (mem_we or mem_re) high for exactly one cycle
// RDWAIT | wait RD_LAT cycles for RAM read data, capture on last cycle
// RESP   | completion: cpu_waitrequest low or jtag_ack high
// ---------------------------------------------------------------------------
module doodlejump_soc_ocimem_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                debugack,
   input  logic [ADDR_W-1:0]   cpu_address,
   input  logic                cpu_read,
   input  logic                cpu_write,
   input  logic [DATA_W-1:0]   cpu_writedata,
   input  logic [DATA_W/8-1:0] cpu_byteenable,
   output logic                cpu_waitrequest,
   output logic [DATA_W-1:0]   cpu_readdata,
   input  logic                jtag_req,
   input  logic                jtag_we,
   input  logic [ADDR_W-1:0]   jtag_addr,
   input  logic [DATA_W-1:0]   jtag_wdata,
   output logic                jtag_ack,
   output logic [DATA_W-1:0]   jtag_rdata,
   output logic                jtag_overrun,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   output logic                mem_we,
   output logic                mem_re,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                grant_jtag
);

   localparam int BE_W = DATA_W / 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_GRANT,
      S_RDWAIT,
      S_RESP
   } state_t;

   state_t              state;
   logic                owner_jtag;
   logic                owner_we;
   logic                last_grant_jtag;
   logic [2:0]          lat_cnt;

   logic                jtag_pending;
   logic                jtag_we_q;
   logic [ADDR_W-1:0]   jtag_addr_q;
   logic [DATA_W-1:0]   jtag_wdata_q;

   logic                cpu_req;
   logic                jtag_resp;
   logic                pick_jtag;

   assign cpu_req   = cpu_read | cpu_write;
   assign jtag_resp = (state == S_RESP) && owner_jtag;

   // JTAG wins when it is the only requester, when debug forces priority,
   // or when the CPU was served last.
   always_comb begin
      pick_jtag = 1'b0;
      if (jtag_pending && (debugack || !cpu_req || !last_grant_jtag))
         pick_jtag = 1'b1;
   end

   // JTAG command capture. The pending slot frees in the JTAG RESP cycle, so
   // a pulse landing in that cycle is taken rather than dropped.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         jtag_pending <= 1'b0;
         jtag_overrun <= 1'b0;
         jtag_we_q    <= 1'b0;
         jtag_addr_q  <= '0;
         jtag_wdata_q <= '0;
      end else begin
         if (jtag_resp)
            jtag_pending <= 1'b0;
         if (jtag_req) begin
            if (!jtag_pending || jtag_resp) begin
               jtag_pending <= 1'b1;
               jtag_we_q    <= jtag_we;
               jtag_addr_q  <= jtag_addr;
               jtag_wdata_q <= jtag_wdata;
            end else begin
               jtag_overrun <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state           <= S_IDLE;
         owner_jtag      <= 1'b0;
         owner_we        <= 1'b0;
         last_grant_jtag <= 1'b1;
         grant_jtag      <= 1'b0;
         lat_cnt         <= '0;
         cpu_waitrequest <= 1'b1;
         cpu_readdata    <= '0;
         jtag_ack        <= 1'b0;
         jtag_rdata      <= '0;
         mem_addr        <= '0;
         mem_wdata       <= '0;
         mem_be          <= '0;
         mem_we          <= 1'b0;
         mem_re          <= 1'b0;
      end else begin
         mem_we          <= 1'b0;
         mem_re          <= 1'b0;
         cpu_waitrequest <= 1'b1;
         jtag_ack        <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pick_jtag) begin
                  owner_jtag      <= 1'b1;
                  owner_we        <= jtag_we_q;
                  last_grant_jtag <= 1'b1;
                  grant_jtag      <= 1'b1;
                  mem_addr        <= jtag_addr_q;
                  mem_wdata       <= jtag_wdata_q;
                  mem_be          <= {BE_W{1'b1}};
                  mem_we          <= jtag_we_q;
                  mem_re          <= !jtag_we_q;
                  state           <= S_GRANT;
               end else if (cpu_req) begin
                  // read+write together is treated as a write
                  owner_jtag      <= 1'b0;
                  owner_we        <= cpu_write;
                  last_grant_jtag <= 1'b0;
                  grant_jtag      <= 1'b0;
                  mem_addr        <= cpu_address;
                  mem_wdata       <= cpu_writedata;
                  mem_be          <= cpu_byteenable;
                  mem_we          <= cpu_write;
                  mem_re          <= !cpu_write;
                  state           <= S_GRANT;
               end
            end
            S_GRANT: begin
               if (owner_we) begin
                  cpu_waitrequest <= owner_jtag;
                  jtag_ack        <= owner_jtag;
                  state           <= S_RESP;
               end else begin
                  lat_cnt <= 3'(RD_LAT - 1);
                  state   <= S_RDWAIT;
               end
            end
            S_RDWAIT: begin
               if (lat_cnt == '0) begin
                  if (owner_jtag)
                     jtag_rdata   <= mem_rdata;
                  else
                     cpu_readdata <= mem_rdata;
                  cpu_waitrequest <= owner_jtag;
                  jtag_ack        <= owner_jtag;
                  state           <= S_RESP;
               end else begin
                  lat_cnt <= lat_cnt - 3'd1;
               end
            end
            S_RESP: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_doodlejump_soc_ocimem_arbiter.sv
// ---------------------------------------------------------------------------
// Directed bench for doodlejump_soc_ocimem_arbiter. Two instances share all
// inputs: u_dut (RD_LAT=1) carries most scenarios, u_dut3 (RD_LAT=3) is
// used for the reset-during-read-wait scenario. Inputs change and outputs
// are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_doodlejump_soc_ocimem_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        debugack;
   logic [7:0]  cpu_address;
   logic        cpu_read;
   logic        cpu_write;
   logic [31:0] cpu_writedata;
   logic [3:0]  cpu_byteenable;
   logic        jtag_req;
   logic        jtag_we;
   logic [7:0]  jtag_addr;
   logic [31:0] jtag_wdata;
   logic [31:0] mem_rdata;

   logic        cpu_waitrequest, jtag_ack, jtag_overrun, mem_we, mem_re, grant_jtag;
   logic [31:0] cpu_readdata, jtag_rdata, mem_wdata;
   logic [7:0]  mem_addr;
   logic [3:0]  mem_be;

   logic        cpu_waitrequest_3, jtag_ack_3, jtag_overrun_3, mem_we_3, mem_re_3, grant_jtag_3;
   logic [31:0] cpu_readdata_3, jtag_rdata_3, mem_wdata_3;
   logic [7:0]  mem_addr_3;
   logic [3:0]  mem_be_3;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   doodlejump_soc_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32), .RD_LAT(1)) u_dut (
      .clk(clk), .reset_n(reset_n), .debugack(debugack),
      .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
      .cpu_writedata(cpu_writedata), .cpu_byteenable(cpu_byteenable),
      .cpu_waitrequest(cpu_waitrequest), .cpu_readdata(cpu_readdata),
      .jtag_req(jtag_req), .jtag_we(jtag_we), .jtag_addr(jtag_addr),
      .jtag_wdata(jtag_wdata), .jtag_ack(jtag_ack), .jtag_rdata(jtag_rdata),
      .jtag_overrun(jtag_overrun), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
      .grant_jtag(grant_jtag)
   );

   doodlejump_soc_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32), .RD_LAT(3)) u_dut3 (
      .clk(clk), .reset_n(reset_n), .debugack(debugack),
      .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
      .cpu_writedata(cpu_writedata), .cpu_byteenable(cpu_byteenable),
      .cpu_waitrequest(cpu_waitrequest_3), .cpu_readdata(cpu_readdata_3),
      .jtag_req(jtag_req), .jtag_we(jtag_we), .jtag_addr(jtag_addr),
      .jtag_wdata(jtag_wdata), .jtag_ack(jtag_ack_3), .jtag_rdata(jtag_rdata_3),
      .jtag_overrun(jtag_overrun_3), .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3),
      .mem_be(mem_be_3), .mem_we(mem_we_3), .mem_re(mem_re_3), .mem_rdata(mem_rdata),
      .grant_jtag(grant_jtag_3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic nxt();
      @(negedge clk);
   endtask

   task automatic do_reset();
      nxt();
      reset_n = 1'b0;
      nxt();
      nxt();
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n        = 1'b0;
      debugack       = 1'b0;
      cpu_address    = '0;
      cpu_read       = 1'b0;
      cpu_write      = 1'b0;
      cpu_writedata  = '0;
      cpu_byteenable = '0;
      jtag_req       = 1'b0;
      jtag_we        = 1'b0;
      jtag_addr      = '0;
      jtag_wdata     = '0;
      mem_rdata      = 32'hBAD0BAD0;
      repeat (3) nxt();

      // reset values
      chk("rst_waitreq", 32'(cpu_waitrequest), 32'd1);
      chk("rst_ack", 32'(jtag_ack), 32'd0);
      chk("rst_strobes", 32'({mem_we, mem_re}), 32'd0);
      chk("rst_grant", 32'(grant_jtag), 32'd0);
      chk("rst_overrun", 32'(jtag_overrun), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_rdata3", cpu_readdata_3 | jtag_rdata_3 | mem_wdata_3, 32'd0);
      chk("rst_misc3", 32'({mem_be_3, jtag_overrun_3, jtag_ack_3, mem_we_3}), 32'd0);
      reset_n = 1'b1;
      nxt();

      // CPU write, request visible in IDLE cycle N
      cpu_write = 1'b1; cpu_address = 8'h10; cpu_writedata = 32'hDEADBEEF; cpu_byteenable = 4'hF;
      nxt();                                        // N+1 GRANT
      chk("wr_we", 32'({mem_we, mem_re}), 32'd2);
      chk("wr_addr", 32'(mem_addr), 32'h10);
      chk("wr_wdata", mem_wdata, 32'hDEADBEEF);
      chk("wr_be", 32'(mem_be), 32'hF);
      chk("wr_wait_n1", 32'(cpu_waitrequest), 32'd1);
      nxt();                                        // N+2 RESP
      chk("wr_wait_n2", 32'(cpu_waitrequest), 32'd0);
      chk("wr_we_n2", 32'(mem_we), 32'd0);
      cpu_write = 1'b0;
      nxt();
      chk("wr_wait_n3", 32'(cpu_waitrequest), 32'd1);

      // JTAG read 0x22, pulse now, pending visible in IDLE N
      jtag_req = 1'b1; jtag_we = 1'b0; jtag_addr = 8'h22;
      nxt();                                        // N
      jtag_req = 1'b0;
      chk("jrd_ack_n", 32'(jtag_ack), 32'd0);
      nxt();                                        // N+1 GRANT
      chk("jrd_re", 32'({mem_we, mem_re}), 32'd1);
      chk("jrd_addr", 32'(mem_addr), 32'h22);
      chk("jrd_be", 32'(mem_be), 32'hF);
      chk("jrd_grant", 32'(grant_jtag), 32'd1);
      nxt();                                        // N+2 RDWAIT
      chk("jrd_re_n2", 32'({mem_we, mem_re, jtag_ack}), 32'd0);
      mem_rdata = 32'h12345678;
      nxt();                                        // N+3 RESP
      chk("jrd_ack", 32'(jtag_ack), 32'd1);
      chk("jrd_rdata", jtag_rdata, 32'h12345678);
      chk("jrd_cpu_wait", 32'(cpu_waitrequest), 32'd1);
      mem_rdata = 32'hBAD0BAD0;
      // pulse landing in the JTAG RESP cycle is accepted
      jtag_req = 1'b1; jtag_we = 1'b1; jtag_addr = 8'h23; jtag_wdata = 32'hCAFEF00D;
      nxt();                                        // IDLE
      jtag_req = 1'b0;
      chk("jrd_ack_pulse", 32'(jtag_ack), 32'd0);
      chk("jrd_hold1", jtag_rdata, 32'h12345678);
      nxt();                                        // GRANT
      chk("jresp_we", 32'({mem_we, mem_re}), 32'd2);
      chk("jresp_addr", 32'(mem_addr), 32'h23);
      chk("jresp_wdata", mem_wdata, 32'hCAFEF00D);
      chk("jresp_no_ovr", 32'(jtag_overrun), 32'd0);
      nxt();                                        // RESP
      chk("jresp_ack", 32'(jtag_ack), 32'd1);
      chk("jrd_hold2", jtag_rdata, 32'h12345678);
      nxt();

      // both pending, debugack=0, after reset: CPU first, then JTAG
      do_reset();
      jtag_req = 1'b1; jtag_we = 1'b1; jtag_addr = 8'h30; jtag_wdata = 32'h11223344;
      nxt();
      jtag_req = 1'b0;
      cpu_read = 1'b1; cpu_address = 8'h05;
      nxt();                                        // GRANT cpu
      chk("rr_grant0", 32'(grant_jtag), 32'd0);
      chk("rr_cpu_re", 32'({mem_we, mem_re}), 32'd1);
      chk("rr_cpu_addr", 32'(mem_addr), 32'h05);
      nxt();                                        // RDWAIT
      chk("rr_wait_rdw", 32'(cpu_waitrequest), 32'd1);
      mem_rdata = 32'hA5A5A5A5;
      nxt();                                        // RESP
      chk("rr_cpu_done", 32'(cpu_waitrequest), 32'd0);
      chk("rr_cpu_rdata", cpu_readdata, 32'hA5A5A5A5);
      mem_rdata = 32'hBAD0BAD0;
      cpu_read = 1'b0;
      nxt();                                        // IDLE
      chk("rr_wait_idle", 32'(cpu_waitrequest), 32'd1);
      nxt();                                        // GRANT jtag
      chk("rr_grant1", 32'(grant_jtag), 32'd1);
      chk("rr_j_we", 32'({mem_we, mem_re}), 32'd2);
      chk("rr_j_addr", 32'(mem_addr), 32'h30);
      chk("rr_j_wdata", mem_wdata, 32'h11223344);
      nxt();                                        // RESP
      chk("rr_j_ack", 32'(jtag_ack), 32'd1);
      chk("rr_cpu_hold", cpu_readdata, 32'hA5A5A5A5);
      nxt();

      // both pending, debugack=1: JTAG first
      do_reset();
      debugack = 1'b1;
      jtag_req = 1'b1; jtag_we = 1'b1; jtag_addr = 8'h31; jtag_wdata = 32'h55667788;
      nxt();
      jtag_req = 1'b0;
      cpu_read = 1'b1; cpu_address = 8'h06;
      nxt();                                        // GRANT jtag
      chk("dbg_grant1", 32'(grant_jtag), 32'd1);
      chk("dbg_j_we", 32'({mem_we, mem_re}), 32'd2);
      chk("dbg_j_addr", 32'(mem_addr), 32'h31);
      nxt();                                        // RESP jtag
      chk("dbg_j_ack", 32'(jtag_ack), 32'd1);
      chk("dbg_wait_a", 32'(cpu_waitrequest), 32'd1);
      nxt();                                        // IDLE
      chk("dbg_wait_b", 32'(cpu_waitrequest), 32'd1);
      nxt();                                        // GRANT cpu
      chk("dbg_grant0", 32'(grant_jtag), 32'd0);
      chk("dbg_cpu_re", 32'({mem_we, mem_re}), 32'd1);
      chk("dbg_cpu_addr", 32'(mem_addr), 32'h06);
      nxt();                                        // RDWAIT
      chk("dbg_wait_c", 32'(cpu_waitrequest), 32'd1);
      mem_rdata = 32'h0BADF00D;
      nxt();                                        // RESP cpu
      chk("dbg_cpu_done", 32'(cpu_waitrequest), 32'd0);
      chk("dbg_cpu_rdata", cpu_readdata, 32'h0BADF00D);
      cpu_read = 1'b0; mem_rdata = 32'hBAD0BAD0; debugack = 1'b0;
      nxt();

      // two JTAG pulses in consecutive cycles: second dropped, overrun sticky
      jtag_req = 1'b1; jtag_we = 1'b1; jtag_addr = 8'h40; jtag_wdata = 32'h00000001;
      nxt();
      jtag_addr = 8'h41; jtag_wdata = 32'h00000002;
      chk("ovr_before", 32'(jtag_overrun), 32'd0);
      nxt();                                        // GRANT first
      jtag_req = 1'b0;
      chk("ovr_set", 32'(jtag_overrun), 32'd1);
      chk("ovr_addr", 32'(mem_addr), 32'h40);
      chk("ovr_we", 32'(mem_we), 32'd1);
      nxt();                                        // RESP
      chk("ovr_ack", 32'(jtag_ack), 32'd1);
      for (int i = 0; i < 3; i++) begin
         nxt();
         chk("ovr_no_second", 32'({mem_we, mem_re, jtag_ack}), 32'd0);
         chk("ovr_sticky", 32'(jtag_overrun), 32'd1);
      end
      nxt();
      reset_n = 1'b0;
      #1;
      chk("ovr_cleared", 32'(jtag_overrun), 32'd0);
      nxt();
      reset_n = 1'b1;
      nxt();

      // RD_LAT=3 instance: reset asserted during RDWAIT
      cpu_read = 1'b1; cpu_address = 8'h11;
      nxt();                                        // GRANT
      chk("l3_re", 32'(mem_re_3), 32'd1);
      chk("l3_addr", 32'(mem_addr_3), 32'h11);
      nxt();                                        // RDWAIT 1
      chk("l3_rdw1", 32'({mem_re_3, cpu_waitrequest_3}), 32'd1);
      nxt();                                        // RDWAIT 2
      mem_rdata = 32'h77777777;
      reset_n = 1'b0;
      #1;
      chk("l3_rst_wait", 32'(cpu_waitrequest_3), 32'd1);
      chk("l3_rst_addr", 32'(mem_addr_3), 32'd0);
      chk("l3_rst_strb", 32'({mem_we_3, mem_re_3, grant_jtag_3}), 32'd0);
      cpu_read = 1'b0;
      nxt();
      reset_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         nxt();
         chk("l3_no_done", 32'({cpu_waitrequest_3, jtag_ack_3, mem_we_3, mem_re_3}), 32'h8);
      end
      chk("l3_rdata", cpu_readdata_3, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/doodlejump_soc_ocimem_arbiter.md
Name: doodlejump_soc_ocimem_arbiter

Overview:
Shares the Nios II on-chip debug memory (OCI RAM) between two requesters: the CPU monitor bus and the JTAG debug-slave command path, which arrives as single-cycle take_action pulses in the clk domain. Arbitration is round-robin. When the CPU is halted in debug (debugack=1), JTAG has fixed priority. Every access is sequenced into one RAM strobe, followed by a read-latency wait and a completion cycle. The block sits between the debug-slave sysclk logic, the CPU data master and the OCI RAM.

Parameters:
ADDR_W, 8, OCI RAM word-address width
DATA_W, 32, data width; byte enables are DATA_W/8
RD_LAT, 1, RAM read latency in cycles; legal range 1..4

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
debugack  in  1  CPU in debug mode; grants JTAG fixed priority
cpu_address  in  ADDR_W  CPU word address
cpu_read  in  1  CPU read request, held until completion
cpu_write  in  1  CPU write request, held until completion
cpu_writedata  in  DATA_W  CPU write data
cpu_byteenable  in  DATA_W/8  CPU byte enables
cpu_waitrequest  out  1  low only in the CPU completion cycle
cpu_readdata  out  DATA_W  read data, valid when cpu_waitrequest=0
jtag_req  in  1  single-cycle JTAG command pulse
jtag_we  in  1  JTAG write (1) / read (0), qualified by jtag_req
jtag_addr  in  ADDR_W  JTAG address, qualified by jtag_req
jtag_wdata  in  DATA_W  JTAG write data, qualified by jtag_req; JTAG writes use all byte enables
jtag_ack  out  1  one-cycle JTAG completion pulse
jtag_rdata  out  DATA_W  JTAG read data, valid with jtag_ack and held afterwards
jtag_overrun  out  1  sticky: a jtag_req was dropped
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_be  out  DATA_W/8  RAM byte enables
mem_we  out  1  RAM write strobe
mem_re  out  1  RAM read strobe
mem_rdata  in  DATA_W  RAM read data, valid RD_LAT cycles after mem_re
grant_jtag  out  1  current or most recent grant belongs to JTAG

Behaviour:
- Reset values (asynchronous): state=IDLE, jtag_pending=0, jtag_overrun=0, last_grant=JTAG, cpu_waitrequest=1, jtag_ack=0, mem_we=0, mem_re=0, all data/address outputs and holding registers 0, grant_jtag=0.
- JTAG capture:
  - A jtag_req pulse with jtag_pending=0 latches jtag_we, jtag_addr and jtag_wdata and sets jtag_pending.
  - A pulse with jtag_pending=1 is dropped and sets jtag_overrun.
  - jtag_pending clears in the JTAG RESP cycle. A new pulse arriving in that same cycle is accepted.
- CPU request = cpu_read | cpu_write. If both are high, the access is treated as a write.
- FSM states: IDLE, GRANT, RDWAIT, RESP.
- IDLE, arbitration among pending requests:
  - debugack=1: JTAG wins if pending.
  - debugack=0 and both pending: the requester not equal to last_grant wins.
  - Only one pending: that one wins.
  - On grant: latch the owner, update last_grant and grant_jtag, go to GRANT.
- GRANT (exactly 1 cycle):
  - mem_addr, mem_wdata and mem_be come from the owner's request.
  - mem_we=1 for a write, mem_re=1 for a read.
  - Next state: RESP for a write; RDWAIT for a read.
- RDWAIT: stays RD_LAT cycles. Counts from the cycle after GRANT; mem_rdata is captured into the owner's holding register on the last RDWAIT cycle. Next state: RESP.
- RESP (1 cycle):
  - CPU owner: cpu_waitrequest=0.
  - JTAG owner: jtag_ack=1.
  - Next state: IDLE. No back-to-back grant from RESP.
- Latency, with request visible in IDLE cycle N:
  - write completes in cycle N+2;
  - read completes in cycle N+2+RD_LAT.
- mem_we and mem_re are never high together, and are high only in GRANT.
- cpu_waitrequest stays 1 in every other cycle, including while idle.
- CPU request withdrawn mid-access: the access still completes. The RAM write is not cancelled.
- Data holding:
  - jtag_rdata holds until the next JTAG read completes.
  - cpu_readdata holds until the next CPU read completes.
- Reset asserted mid-operation: immediate return to IDLE, strobes low, pending and overrun cleared. An in-flight access is lost.

Test Plan:
- CPU write addr 0x10, data 0xDEADBEEF, be=0xF, idle otherwise -> mem_we=1 with those values in cycle N+1; cpu_waitrequest=0 in N+2 only.
- JTAG read addr 0x22, RAM returning 0x12345678, RD_LAT=1 -> mem_re in N+1; jtag_ack pulse in N+3; jtag_rdata=0x12345678 held afterwards.
- CPU read and JTAG request both pending in the same IDLE cycle, debugack=0, after reset -> CPU granted first, JTAG next; grant_jtag sequence 0 then 1.
- Same as above with debugack=1 -> JTAG granted first; CPU completes only after the JTAG RESP cycle.
- Two jtag_req pulses 1 cycle apart -> first serviced, second dropped, jtag_overrun=1 until reset_n is asserted.
- reset_n asserted during RDWAIT with RD_LAT=3 -> all outputs return to reset values asynchronously; no ack or completion after release.
